uart_bus_if: RTL and testbench
==============================

UART_BUS_IF -- requirements
Module: uart_bus_if

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, 2..64.
REQ-002 Parameter DIV_RESET, default 8'd12, reset value of the baud divisor register.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cs  in  1  bus select; one access per cycle when high.
REQ-007 we  in  1  1 = write, 0 = read; valid with cs.
REQ-008 addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
REQ-009 wdata  in  8  write data.
REQ-010 rdata  out  8  read data, combinational from addr and state.
REQ-011 irq  out  1  level interrupt request, registered.
REQ-012 bitxce  out  1  one-cycle strobe to the UART core, 8 per bit time.
REQ-013 load  out  1  one-cycle transmit load strobe to the UART core.
REQ-014 d  out  8  byte to transmit; valid while load is high.
REQ-015 txbusy  in  1  UART core transmit status.
REQ-016 bytercvd  in  1  UART core one-cycle received-byte strobe.
REQ-017 q  in  8  UART core received byte; valid with bytercvd.

Function
REQ-018 Baud: 8-bit counter reloads from DIV on reaching 0, otherwise decrements; bitxce = 1 in the cycle it equals 0, giving period DIV+1 clocks; DIV=0 gives bitxce every cycle.
REQ-019 A DIV write takes effect at the next reload; the running count is not disturbed.
REQ-020 RX FIFO: bytercvd pushes q; push while full with no pop in the same cycle drops the byte and sets sticky rx_ovr.
REQ-021 Read of DATA (cs & !we & addr==0): rdata = RX head; pops when non-empty; rdata = 8'h00 with no pop when empty.
REQ-022 Simultaneous RX push and pop: both complete; count unchanged; a full FIFO accepts the byte.
REQ-023 Write of DATA pushes wdata to TX FIFO; write while full drops it and sets sticky tx_ovf.
REQ-024 TX drain: load = 1 when TX non-empty, txbusy = 0, and load was 0 in the previous cycle; the same cycle drives d = head and pops; no two consecutive load cycles are issued, covering the one-cycle txbusy rise delay.
REQ-025 Simultaneous TX push and drain pop: both complete.
REQ-026 STATUS read: bit0 rx_nempty, bit1 tx_nfull, bit2 rx_ovr, bit3 tx_idle (TX empty & !txbusy & !load), bit4 tx_ovf, bits6:5 = 0, bit7 = irq; no side effects.
REQ-027 CTRL: bit0 rx_ie, bit1 tx_ie are read/write; a write with bit7 = 1 clears rx_ovr and tx_ovf; a same-cycle set wins over the clear; a CTRL read returns {6'b0, tx_ie, rx_ie}.
REQ-028 DIV is read/write.
REQ-029 irq next = (rx_ie & rx_nempty) | (rx_ie & rx_ovr) | (tx_ie & tx_idle).
REQ-030 FIFO pointers wrap modulo DEPTH; count width is log2(DEPTH)+1; full = count==DEPTH.

Reset
REQ-031 On rst: both FIFOs empty, rx_ovr = tx_ovf = 0, rx_ie = tx_ie = 0, DIV = DIV_RESET, baud counter = DIV_RESET, irq = 0, load = 0, bitxce = 0.
REQ-032 A reset mid-transmission discards queued TX bytes; a byte already loaded in the core completes unaffected; FIFO data RAM is not cleared.

Structure
REQ-033 Shared package uart_pkg holds the register address constants, STATUS and CTRL bit positions, and the DIV_RESET default.
REQ-034 One sub-module, uart_fifo_m (parameter DEPTH, ports push/pop/din/dout/full/empty), is instantiated twice, for RX and TX.

Verification
REQ-035 DIV=3 after reset -> bitxce period 4 clocks once the counter reloads; DIV=0 -> bitxce high every cycle.
REQ-036 Write 0x41, 0x42 to DATA with txbusy held 0 -> load pulses with d=0x41 then d=0x42, never in adjacent cycles; STATUS bit3 = 1 afterwards.
REQ-037 9 bytercvd pulses, q = 0x01..0x09, DEPTH=8 -> 8 DATA reads return 0x01..0x08, STATUS bit2 = 1; a CTRL write of 0x80 clears it; a 9th read returns 0x00.
REQ-038 RX full with bytercvd and a DATA read in the same cycle -> read returns the head, the new byte is stored, rx_ovr stays 0.
REQ-039 CTRL=0x01 then one bytercvd -> irq = 1 the next cycle; a DATA read drops irq the following cycle.
REQ-040 rst asserted with 3 TX bytes queued -> no further load, STATUS = 0x0A on the next read with txbusy = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART bus interface: register map, STATUS/CTRL
// bit positions and the default baud divisor.
package uart_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_NFULL  = 1;
  localparam int ST_RX_OVR    = 2;
  localparam int ST_TX_IDLE   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_IRQ       = 7;

  // CTRL bit positions
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_CLR   = 7;

  // Baud divisor value loaded at reset
  localparam logic [7:0] DIV_RESET_DEFAULT = 8'd12;

endpackage

// File: rtl/uart_fifo_m.sv
// Byte FIFO used for both the RX and TX queues. The head is readable
// combinationally so the bus can return it in the same cycle it pops.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module uart_fifo_m #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];

  // Data storage; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_if.sv
// Bus-side register block for a UART core: RX/TX FIFOs, baud strobe
// generator, sticky overflow flags, interrupt enables and level irq.
module uart_bus_if
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       bitxce,
  output logic       load,
  output logic [7:0] d,
  input  logic       txbusy,
  input  logic       bytercvd,
  input  logic [7:0] q
);

  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_dout, tx_dout;
  logic       rd_data, wr_data, wr_ctrl, wr_div;
  logic       rx_pop, rx_ovr_set, tx_ovf_set, ctrl_clr, tx_idle;
  logic       rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
  logic       rx_ie_q, tx_ie_q, irq_q, irq_d, load_prev_q, bitxce_q;
  logic [7:0] div_q, cnt_q, cnt_d, status;

  assign rd_data = cs & ~we & (addr == ADDR_DATA);
  assign wr_data = cs &  we & (addr == ADDR_DATA);
  assign wr_ctrl = cs &  we & (addr == ADDR_CTRL);
  assign wr_div  = cs &  we & (addr == ADDR_DIV);

  // RX pops only when there is something to pop; a pop frees a slot for a
  // byte arriving in the same cycle, so no overflow in that case.
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_ovr_set = bytercvd & rx_full & ~rx_pop;

  // Load is suppressed for one cycle after each load so the core's txbusy
  // (which rises a cycle late) is seen before the next byte is offered.
  assign load       = ~rst & ~tx_empty & ~txbusy & ~load_prev_q;
  assign d          = tx_dout;
  assign tx_ovf_set = wr_data & tx_full & ~load;
  assign tx_idle    = tx_empty & ~txbusy & ~load;

  // Overflow flags: a new overflow in the clearing cycle wins
  assign ctrl_clr = wr_ctrl & wdata[CTRL_CLR];
  assign rx_ovr_d = rx_ovr_set | (rx_ovr_q & ~ctrl_clr);
  assign tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~ctrl_clr);

  // Baud counter reloads from the divisor register only when it hits zero
  assign cnt_d = (cnt_q == 8'd0) ? div_q : cnt_q - 8'd1;

  assign irq_d = (rx_ie_q & ~rx_empty) | (rx_ie_q & rx_ovr_q) | (tx_ie_q & tx_idle);
  assign irq    = irq_q;
  assign bitxce = bitxce_q;

  uart_fifo_m #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bytercvd),
    .pop   (rx_pop),
    .din   (q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  uart_fifo_m #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (load),
    .din   (wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Register state: flags, enables, divisor, baud counter, irq and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      div_q       <= DIV_RESET;
      cnt_q       <= DIV_RESET;
      irq_q       <= 1'b0;
      load_prev_q <= 1'b0;
      bitxce_q    <= 1'b0;
    end else begin
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      if (wr_ctrl) begin
        rx_ie_q <= wdata[CTRL_RX_IE];
        tx_ie_q <= wdata[CTRL_TX_IE];
      end
      if (wr_div) div_q <= wdata;
      cnt_q       <= cnt_d;
      bitxce_q    <= (cnt_d == 8'd0);
      irq_q       <= irq_d;
      load_prev_q <= load;
    end
  end

  // STATUS word assembly
  always_comb begin
    status               = 8'h00;
    status[ST_RX_NEMPTY] = ~rx_empty;
    status[ST_TX_NFULL]  = ~tx_full;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_TX_IDLE]   = tx_idle;
    status[ST_TX_OVF]    = tx_ovf_q;
    status[ST_IRQ]       = irq_q;
  end

  // Read mux; an empty RX FIFO reads as zero
  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_DATA:   rdata = rx_empty ? 8'h00 : rx_dout;
      ADDR_STATUS: rdata = status;
      ADDR_CTRL:   rdata = {6'b0, tx_ie_q, rx_ie_q};
      ADDR_DIV:    rdata = div_q;
      default:     rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_if.sv
// Testbench for uart_bus_if: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_bus_if;
  import uart_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, cs, we, irq, bitxce, load, txbusy, bytercvd;
  logic [1:0] addr;
  logic [7:0] wdata, rdata, d, q;

  always #5 clk = ~clk;

  uart_bus_if #(.DEPTH(DEPTH), .DIV_RESET(8'd12)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq),
    .bitxce   (bitxce),
    .load     (load),
    .d        (d),
    .txbusy   (txbusy),
    .bytercvd (bytercvd),
    .q        (q)
  );

  int  checks = 0;
  int  passed = 0;
  int  cyc    = 0;
  bit  done   = 0;

  // Reference model state
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  bit         m_rx_ovr, m_tx_ovf, m_rx_ie, m_tx_ie, m_irq, m_lp;
  logic [7:0] m_div, m_cnt;

  // Logs of observed strobes
  int         ld_cyc[$];
  logic [7:0] ld_d[$];
  int         bx_cyc[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @cyc %0d: got %02h expected %02h", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  function automatic bit exp_load();
    return !rst && (m_tx.size() > 0) && !txbusy && !m_lp;
  endfunction

  function automatic bit exp_idle();
    return (m_tx.size() == 0) && !txbusy && !exp_load();
  endfunction

  function automatic logic [7:0] exp_rdata();
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      2'd0: r = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
      2'd1: r = {m_irq, 2'b00, m_tx_ovf, exp_idle(), m_rx_ovr,
                 (m_tx.size() < DEPTH), (m_rx.size() > 0)};
      2'd2: r = {6'b0, m_tx_ie, m_rx_ie};
      default: r = m_div;
    endcase
    return r;
  endfunction

  // Model advance on every rising edge from the inputs held during the cycle
  always @(posedge clk) begin
    bit ld, irq_n;
    logic [7:0] old_div;
    cyc++;
    if (rst) begin
      m_rx.delete();
      m_tx.delete();
      m_rx_ovr = 0; m_tx_ovf = 0; m_rx_ie = 0; m_tx_ie = 0;
      m_irq = 0; m_lp = 0;
      m_div = 8'd12; m_cnt = 8'd12;
    end else begin
      ld    = exp_load();
      irq_n = (m_rx_ie && m_rx.size() > 0) || (m_rx_ie && m_rx_ovr) || (m_tx_ie && exp_idle());
      if (cs && !we && addr == 2'd0 && m_rx.size() > 0) void'(m_rx.pop_front());
      if (cs && we && addr == 2'd2) begin
        m_rx_ie = wdata[0];
        m_tx_ie = wdata[1];
        if (wdata[7]) begin m_rx_ovr = 0; m_tx_ovf = 0; end
      end
      if (bytercvd) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(q); else m_rx_ovr = 1;
      end
      if (ld) void'(m_tx.pop_front());
      if (cs && we && addr == 2'd0) begin
        if (m_tx.size() < DEPTH) m_tx.push_back(wdata); else m_tx_ovf = 1;
      end
      old_div = m_div;
      if (cs && we && addr == 2'd3) m_div = wdata;
      m_cnt = (m_cnt == 8'd0) ? old_div : m_cnt - 8'd1;
      m_irq = irq_n;
      m_lp  = ld;
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (!done) begin
      check8("load", {7'b0, load}, {7'b0, exp_load()});
      if (!rst && cyc > 0) begin
        if (exp_load()) check8("d", d, m_tx[0]);
        check8("bitxce", {7'b0, bitxce}, {7'b0, (m_cnt == 8'd0)});
        check8("irq", {7'b0, irq}, {7'b0, m_irq});
        check8("rdata", rdata, exp_rdata());
      end
      if (load === 1'b1) begin ld_cyc.push_back(cyc); ld_d.push_back(d); end
      if (bitxce === 1'b1) bx_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic access(input logic [1:0] a, input logic [7:0] v);
    cs = 1; we = 1; addr = a; wdata = v;
    @(posedge clk); #1;
    cs = 0; we = 0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    cs = 1; we = 0; addr = a;
    @(negedge clk);
    check8(name, rdata, exp);
    $display("read addr=%0d data=%02h exp=%02h (%s)", a, rdata, exp, name);
    @(posedge clk); #1;
    cs = 0;
  endtask

  task automatic rcv(input logic [7:0] v);
    bytercvd = 1; q = v;
    @(posedge clk); #1;
    bytercvd = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cs = 0; we = 0; addr = 0; wdata = 0; txbusy = 0; bytercvd = 0; q = 0;
    step(3);
    rst = 0;
    @(negedge clk);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_bitxce", {7'b0, bitxce}, 8'h00);
    check8("rst_load", {7'b0, load}, 8'h00);
    @(posedge clk); #1;
    read_chk("rst_div", ADDR_DIV, 8'h0C);
    read_chk("rst_status", ADDR_STATUS, 8'h0A);
    read_chk("rst_ctrl", ADDR_CTRL, 8'h00);

    // Baud: DIV=3 gives period 4 after the running count reloads
    access(ADDR_DIV, 8'd3);
    bx_cyc.delete();
    step(40);
    check_int("bx_count_div3", (bx_cyc.size() >= 3) ? 1 : 0, 1);
    if (bx_cyc.size() >= 3) begin
      check_int("bx_period_a", bx_cyc[$] - bx_cyc[$-1], 4);
      check_int("bx_period_b", bx_cyc[$-1] - bx_cyc[$-2], 4);
    end
    // DIV=0: strobe every cycle
    access(ADDR_DIV, 8'd0);
    step(16);
    bx_cyc.delete();
    step(8);
    check_int("bx_div0", bx_cyc.size(), 8);

    // TX drain: two bytes, never adjacent loads
    ld_cyc.delete(); ld_d.delete();
    access(ADDR_DATA, 8'h41);
    access(ADDR_DATA, 8'h42);
    step(6);
    check_int("tx_load_count", ld_cyc.size(), 2);
    if (ld_cyc.size() == 2) begin
      $display("load d=%02h cyc=%0d ; load d=%02h cyc=%0d", ld_d[0], ld_cyc[0], ld_d[1], ld_cyc[1]);
      check8("tx_d0", ld_d[0], 8'h41);
      check8("tx_d1", ld_d[1], 8'h42);
      check_int("tx_not_adjacent", (ld_cyc[1] - ld_cyc[0] > 1) ? 1 : 0, 1);
    end
    read_chk("tx_idle_status", ADDR_STATUS, 8'h0A);

    // RX overflow: 9 bytes into 8 entries
    for (int i = 1; i <= 9; i++) rcv(8'(i));
    read_chk("rx_ovr_status", ADDR_STATUS, 8'h0F);
    access(ADDR_CTRL, 8'h80);
    read_chk("rx_ovr_cleared", ADDR_STATUS, 8'h0B);
    for (int i = 1; i <= 8; i++) read_chk("rx_data", ADDR_DATA, 8'(i));
    read_chk("rx_empty_read", ADDR_DATA, 8'h00);

    // Full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) rcv(8'h10 + 8'(i));
    bytercvd = 1; q = 8'h18; cs = 1; we = 0; addr = ADDR_DATA;
    @(negedge clk);
    check8("rx_full_pushpop_head", rdata, 8'h10);
    @(posedge clk); #1;
    bytercvd = 0; cs = 0;
    read_chk("rx_full_pushpop_status", ADDR_STATUS, 8'h0B);
    for (int i = 1; i <= 8; i++) read_chk("rx_data2", ADDR_DATA, 8'h10 + 8'(i));
    read_chk("rx_empty_read2", ADDR_DATA, 8'h00);

    // RX interrupt
    access(ADDR_CTRL, 8'h01);
    rcv(8'h55);
    step(1);
    @(negedge clk);
    check8("irq_rx_set", {7'b0, irq}, 8'h01);
    @(posedge clk); #1;
    read_chk("irq_rx_data", ADDR_DATA, 8'h55);
    step(1);
    @(negedge clk);
    check8("irq_rx_drop", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    // TX idle interrupt
    access(ADDR_CTRL, 8'h02);
    step(1);
    @(negedge clk);
    check8("irq_tx_idle", {7'b0, irq}, 8'h01);
    @(posedge clk); #1;
    access(ADDR_CTRL, 8'h00);
    step(2);

    // Overflow set in the same cycle as a clear: set wins
    for (int i = 0; i < 8; i++) rcv(8'h20 + 8'(i));
    bytercvd = 1; q = 8'h28; cs = 1; we = 1; addr = ADDR_CTRL; wdata = 8'h80;
    @(posedge clk); #1;
    bytercvd = 0; cs = 0; we = 0;
    read_chk("set_wins_status", ADDR_STATUS, 8'h0F);

    // TX overflow while the core is busy
    txbusy = 1;
    for (int i = 0; i < 9; i++) access(ADDR_DATA, 8'h30 + 8'(i));
    read_chk("tx_ovf_status", ADDR_STATUS, 8'h15);
    rst = 1; step(1); rst = 0;

    // Reset with TX bytes queued discards them
    ld_cyc.delete(); ld_d.delete();
    for (int i = 0; i < 3; i++) access(ADDR_DATA, 8'h60 + 8'(i));
    read_chk("tx_queued_status", ADDR_STATUS, 8'h02);
    rst = 1; step(1); rst = 0;
    txbusy = 0;
    read_chk("post_rst_status", ADDR_STATUS, 8'h0A);
    step(5);
    check_int("post_rst_no_load", ld_cyc.size(), 0);
    read_chk("post_rst_div", ADDR_DIV, 8'h0C);
    read_chk("post_rst_data", ADDR_DATA, 8'h00);

    step(2);
    done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
